mul_share_arb: RTL and testbench
================================

# mul_share_arb

Shares one iterative 4-bit shift-and-add multiplier between NREQ requesters. Each requester presents an operand pair under a valid/ready handshake. The arbiter grants one requester at a time in round-robin order and sequences the core through W add/shift iterations. It returns the 2W-bit product on a shared response bus, tagged with the requester id. The block sits between the requesting control units and the multiplier datapath; it replaces the per-unit single-cycle multipliers.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 4, operand width; product is 2W bits
- clk  in  1  rising-edge clock
- rst_an  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester operand valid
- req_a  in  NREQ*W  multiplier operands; requester i occupies bits [i*W +: W]
- req_b  in  NREQ*W  multiplicand operands; same packing as req_a
- req_ready  out  NREQ  one-hot accept pulse, registered
- rsp_valid  out  NREQ  one-hot result pulse, registered
- rsp_op  out  2W  product, shared by all requesters
- rsp_id  out  $clog2(NREQ)  index of the requester that owns rsp_op
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any req_valid is high at a clock edge:
  - pick the winner (see arbitration);
  - latch that winner's a and b;
  - pulse req_ready[winner] for exactly one cycle;
  - set cnt=0, acc=0, mcand={W'b0,b}, mplier=a;
  - go to BUSY.
- BUSY: on each edge, if mplier[0] then acc+=mcand; mcand<<=1; mplier>>=1; cnt++. After W iterations, go to DONE.
- DONE: for one cycle, rsp_valid[id]=1, rsp_op=acc, rsp_id=id. Then go to IDLE.
- Arbitration, round-robin: the search starts at last_id+1 modulo NREQ. last_id updates on every grant. last_id resets to NREQ-1, so requester 0 wins first.
- Arithmetic is unsigned and acc is 2W bits. It cannot overflow: 15*15=225 fits in 8 bits.
- Zero operands still take the full W iterations. Latency does not depend on the data.
- Requester rules:
  - hold req_valid, a and b stable until req_ready is sampled high;
  - drop req_valid at that edge, or keep it high to request again.
- A request withdrawn before it is granted is legal and has no effect.
- rsp_valid is never backpressured. The requester must capture the result in its DONE cycle.
- rsp_op and rsp_id hold their last values between responses.
- Reset (rst_an low, any state):
  - state goes to IDLE and last_id to NREQ-1;
  - all outputs go to 0: req_ready, rsp_valid, rsp_op, rsp_id, busy;
  - any in-flight operation is discarded and no response is issued.

## Timing
- Edge E0 (IDLE, valid seen): grant. req_ready[w] is high in cycle E0..E1 and busy rises.
- Edges E1..EW: the W iterations.
- Cycle EW..EW+1: state DONE with rsp_valid high. Accept-to-result latency is W cycles.
- Edge EW+1: back to IDLE. The earliest next grant is EW+2.
- Throughput is one product per W+2 cycles, which is 6 cycles at W=4.
- No grant is made in BUSY or DONE. A new req_valid arriving during an operation waits for IDLE.

## Configuration
- MUL_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest-index valid requester always wins, and last_id is not implemented.
- MUL_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.
- All other behaviour and timing are the same in both builds.

## Structure
- Package mul_arb_pkg holds:
  - the state enum {IDLE, BUSY, DONE};
  - default constants NREQ_DEF=4 and W_DEF=4;
  - an id-width helper function.
- Sub-module shift_add_mul_core contains the iterative datapath: start, a, b in; done and product out; with the cnt, acc, mcand and mplier registers.
- mul_share_arb contains the FSM, the arbiter and the response registers.

## Test plan
- Reset: hold rst_an low with random inputs -> all outputs 0. Release and raise req_valid[0] -> req_ready[0] pulses in the cycle after the first edge.
- Single request: req0 with a=13, b=11 -> one req_ready[0] pulse, then rsp_valid[0] 4 cycles after the accept edge with rsp_op=143 and rsp_id=0.
- All four valid, each held until accepted, with (15,15), (0,9), (7,3), (8,8) -> served in order 0,1,2,3, 6 cycles apart. Products are 225, 0, 21, 64.
- Fairness: req0 and req2 held continuously -> grants alternate 0,2,0,2. Under MUL_ARB_FIXED_PRIO_EN, req0 wins every grant.
- Reset mid-operation: pull rst_an low during BUSY iteration 2 -> no rsp_valid, busy=0. After release, requester 0 is granted first.
- Withdrawn request: req1 raised and dropped during another requester's BUSY -> req1 is never granted and no rsp_valid[1] appears.

Source files
------------

// File: rtl/mul_share_arb_pkg.sv
// ============================================================================
//  Module      : mul_arb_pkg
//  Description : Shared types and constants for the shared multiplier arbiter
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

  // Requester-id width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_share_arb_if.sv
// ============================================================================
//  Module      : mul_share_arb_if
//  Description : Request/response bundle between requesters and the arbiter
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mul_share_arb_if #(
  parameter int NREQ = mul_arb_pkg::NREQ_DEF,
  parameter int W    = mul_arb_pkg::W_DEF
);
  localparam int IDW = mul_arb_pkg::id_width(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_op;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_op, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_op, rsp_id, busy
  );

endinterface

`default_nettype wire

// File: rtl/mul_share_arb_core.sv
// ============================================================================
//  Module      : shift_add_mul_core
//  Description : Iterative unsigned shift-and-add multiplier, W cycles/product
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_add_mul_core #(
  parameter int W = mul_arb_pkg::W_DEF
) (
  input  wire logic           clk,
  input  wire logic           rst_an,
  input  wire logic           start,
  input  wire logic [W-1:0]   a,
  input  wire logic [W-1:0]   b,
  output logic                done,
  output logic [2*W-1:0]      product
);
  localparam int CW = $clog2(W) + 1;

  logic           running;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc_nxt;
  logic           last_iter;

  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign last_iter = running && (cnt == CW'(W - 1));

  // done marks the final iteration; product is the value acc takes at that edge
  assign done    = last_iter;
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= {{W{1'b0}}, b};
      mplier  <= a;
    end else if (running) begin
      acc     <= acc_nxt;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + CW'(1);
      if (last_iter) running <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_share_arb.sv
// ============================================================================
//  Module      : mul_share_arb
//  Description : Round-robin (or fixed-priority with MUL_ARB_FIXED_PRIO_EN)
//                arbiter sharing one iterative multiplier among NREQ users
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  wire logic         clk,
  input  wire logic         rst_an,
  mul_share_arb_if.slave    bus
);
  localparam int IDW = id_width(NREQ);

  state_e         state, state_nxt;
  logic           win_valid;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cur_id;
  logic           start;
  logic           core_done;
  logic [2*W-1:0] core_product;

  logic [NREQ-1:0] ready_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic [2*W-1:0]  rsp_op_r;
  logic [IDW-1:0]  rsp_id_r;

  assign start = (state == IDLE) && win_valid;

`ifdef MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[IDW'(k)]) begin
        win_valid = 1'b1;
        win_id    = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0] last_id;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Scan downward so the candidate closest to last_id+1 is written last and wins
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    sum       = '0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, last_id} + (IDW+1)'(1) + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (bus.req_valid[idx]) begin
        win_valid = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an)    last_id <= IDW'(NREQ - 1);
    else if (start) last_id <= win_id;
  end
`endif

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = BUSY;
      BUSY:    if (core_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      ready_r     <= '0;
      rsp_valid_r <= '0;
      rsp_op_r    <= '0;
      rsp_id_r    <= '0;
      cur_id      <= '0;
    end else begin
      ready_r     <= '0;
      rsp_valid_r <= '0;
      if (start) begin
        ready_r[win_id] <= 1'b1;
        cur_id          <= win_id;
      end
      if ((state == BUSY) && core_done) begin
        rsp_valid_r[cur_id] <= 1'b1;
        rsp_op_r            <= core_product;
        rsp_id_r            <= cur_id;
      end
    end
  end

  shift_add_mul_core #(.W(W)) u_core (
    .clk     (clk),
    .rst_an  (rst_an),
    .start   (start),
    .a       (bus.req_a[win_id*W +: W]),
    .b       (bus.req_b[win_id*W +: W]),
    .done    (core_done),
    .product (core_product)
  );

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_op    = rsp_op_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arb.sv
// ============================================================================
//  Module      : tb_mul_share_arb
//  Description : Scoreboard bench for mul_share_arb (grants and products)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_share_arb;
  import mul_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 4;

  typedef struct {
    int id;
    int op;
  } rsp_t;

  logic clk    = 1'b0;
  logic rst_an = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;

  int   gq[$];
  rsp_t rq[$];
  int   last_gcyc = -1;
  int   prev_gcyc = -1;
  bit   spacing   = 1'b0;

  always #5 clk = ~clk;

  mul_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  mul_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk    (clk),
    .rst_an (rst_an),
    .bus    (bus)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input int a, input int b);
    rsp_t r;
    r.id = id;
    r.op = a * b;
    gq.push_back(id);
    rq.push_back(r);
  endtask

  task automatic request(input int id, input int a, input int b);
    bus.req_a[id*W +: W] = W'(a);
    bus.req_b[id*W +: W] = W'(b);
    bus.req_valid[id]    = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
        return;
      end
    end
    check("request_timeout", 0, 1);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rq.size() == 0 && gq.size() == 0 && !bus.busy) return;
    end
    check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_an        = 1'b0;
    bus.req_valid = '0;
    gq.delete();
    rq.delete();
    prev_gcyc = -1;
    repeat (2) @(posedge clk);
    #1;
    rst_an = 1'b1;
  endtask

  // Monitor: every grant and every response is matched against the queues
  initial begin
    int   eg;
    rsp_t er;
    forever begin
      @(negedge clk);
      if (rst_an) begin
        if (bus.req_ready != '0) begin
          if (gq.size() == 0) begin
            check("unexpected_grant", int'(bus.req_ready), 0);
          end else begin
            eg = gq.pop_front();
            check("grant_onehot", int'(bus.req_ready), 1 << eg);
          end
          if (spacing && prev_gcyc >= 0) check("grant_spacing", cyc - prev_gcyc, 6);
          prev_gcyc = cyc;
          last_gcyc = cyc;
        end
        if (bus.rsp_valid != '0) begin
          if (rq.size() == 0) begin
            check("unexpected_rsp", int'(bus.rsp_valid), 0);
          end else begin
            er = rq.pop_front();
            check("rsp_valid_onehot", int'(bus.rsp_valid), 1 << er.id);
            check("rsp_id", int'(bus.rsp_id), er.id);
            check("rsp_op", int'(bus.rsp_op), er.op);
            check("rsp_latency", cyc - last_gcyc, 4);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Reset with random inputs
    repeat (4) begin
      @(posedge clk);
      #1;
      bus.req_valid = NREQ'($urandom);
      bus.req_a     = (NREQ*W)'($urandom);
      bus.req_b     = (NREQ*W)'($urandom);
      #1;
      check("rst_req_ready", int'(bus.req_ready), 0);
      check("rst_rsp_valid", int'(bus.rsp_valid), 0);
      check("rst_rsp_op",    int'(bus.rsp_op), 0);
      check("rst_rsp_id",    int'(bus.rsp_id), 0);
      check("rst_busy",      int'(bus.busy), 0);
    end
    bus.req_valid      = 4'b0001;
    bus.req_a[0 +: W]  = 4'd3;
    bus.req_b[0 +: W]  = 4'd5;
    push_exp(0, 3, 5);
    rst_an = 1'b1;
    @(posedge clk);
    #1;
    check("first_grant_ready", int'(bus.req_ready), 1);
    check("first_grant_busy",  int'(bus.busy), 1);
    bus.req_valid[0] = 1'b0;
    wait_drain();

    // Single request
    do_reset();
    push_exp(0, 13, 11);
    request(0, 13, 11);
    wait_drain();

    // All four at once, served in order 0..3
    do_reset();
    spacing = 1'b1;
    push_exp(0, 15, 15);
    push_exp(1, 0, 9);
    push_exp(2, 7, 3);
    push_exp(3, 8, 8);
    fork
      request(0, 15, 15);
      request(1, 0, 9);
      request(2, 7, 3);
      request(3, 8, 8);
    join
    wait_drain();

    // Fairness: req0 and req2 both keep requesting
    do_reset();
    spacing = 1'b1;
`ifdef MUL_ARB_FIXED_PRIO_EN
    push_exp(0, 2, 3);
    push_exp(0, 5, 5);
    push_exp(2, 4, 4);
    push_exp(2, 9, 7);
`else
    push_exp(0, 2, 3);
    push_exp(2, 4, 4);
    push_exp(0, 5, 5);
    push_exp(2, 9, 7);
`endif
    fork
      begin
        request(0, 2, 3);
        request(0, 5, 5);
      end
      begin
        request(2, 4, 4);
        request(2, 9, 7);
      end
    join
    wait_drain();
    spacing = 1'b0;

    // Withdrawn request: req1 pulses only while another op is BUSY
    do_reset();
    push_exp(2, 6, 7);
    fork
      request(2, 6, 7);
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.req_a[1*W +: W] = 4'd5;
        bus.req_b[1*W +: W] = 4'd5;
        bus.req_valid[1]    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid[1]    = 1'b0;
      end
    join
    wait_drain();
    repeat (8) @(negedge clk);
    check("withdrawn_no_pending", gq.size(), 0);

    // Reset during the second iteration
    do_reset();
    push_exp(0, 9, 9);
    request(0, 9, 9);
    @(posedge clk);
    #1;
    rst_an = 1'b0;
    #1;
    check("midrst_busy",      int'(bus.busy), 0);
    check("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    check("midrst_rsp_op",    int'(bus.rsp_op), 0);
    rq.delete();
    gq.delete();
    repeat (6) begin
      @(negedge clk);
      check("midrst_hold_rsp", int'(bus.rsp_valid), 0);
    end
    @(posedge clk);
    #1;
    rst_an = 1'b1;
    prev_gcyc = -1;
    push_exp(0, 1, 2);
    push_exp(1, 3, 4);
    fork
      request(0, 1, 2);
      request(1, 3, 4);
    join
    wait_drain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
